// File: rtl/dsamp_pkg.sv
// dsamp_pkg: shared types and constants for the dsamp_box raster downsampler.
package dsamp_pkg;

   // Run-time processing mode; the reserved code behaves as bypass.
   typedef enum logic [1:0] {
      DSAMP_BYPASS = 2'd0,
      DSAMP_DECIM  = 2'd1,
      DSAMP_AVG    = 2'd2,
      DSAMP_RSVD   = 2'd3
   } dsamp_mode_e;

   // Frame-level control state.
   typedef enum logic {
      DSAMP_IDLE   = 1'b0,
      DSAMP_ACTIVE = 1'b1
   } dsamp_state_e;

   // Input-to-output delay in pixel clocks, for both data and vsync.
   localparam int DSAMP_LAT = 2;

   // Per-channel accumulator width: an F x F block sum of DATA_WIDTH values.
   function automatic int acc_width(input int data_width, input int factor_log2);
      return data_width + 2 * factor_log2;
   endfunction

endpackage

// File: rtl/dsamp_sdp_ram.sv
// dsamp_sdp_ram: simple dual-port line accumulator RAM, one write port and
// one registered read port. Contents are not reset; the first row of every
// block-row overwrites the entries it later reads.
module dsamp_sdp_ram #(
   parameter int DEPTH  = 640,
   parameter int WIDTH  = 10,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Synchronous write and registered read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/dsamp_box.sv
// dsamp_box: reduces a raster stream by F = 2^FACTOR_LOG2 in both directions
// using bypass, decimate (top-left pixel) or box-average (rounded mean).
// Two register stages: stage 1 holds the completed horizontal block and the
// RAM read result, stage 2 is the registered output.
module dsamp_box
   import dsamp_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int CHANNELS    = 1,
   parameter int LINE_WIDTH  = 1280,
   parameter int FRAME_LINES = 720,
   parameter int FACTOR_LOG2 = 1
) (
   input  logic                           dsamp_clk,
   input  logic                           dsamp_rst_n,
   input  logic [1:0]                     dsamp_mode,
   input  logic                           dsamp_in_vsync,
   input  logic                           dsamp_in_href,
   input  logic [CHANNELS*DATA_WIDTH-1:0] dsamp_in_pixel,
   output logic                           dsamp_out_vsync,
   output logic                           dsamp_out_href,
   output logic [CHANNELS*DATA_WIDTH-1:0] dsamp_out_pixel,
   output dsamp_state_e                   dsamp_state
);

   localparam int F      = 1 << FACTOR_LOG2;
   localparam int AW     = acc_width(DATA_WIDTH, FACTOR_LOG2);
   localparam int PW     = CHANNELS * DATA_WIDTH;
   localparam int COL_W  = $clog2(LINE_WIDTH + 1);
   localparam int ROW_W  = $clog2(FRAME_LINES + 1);
   localparam int DEPTH  = LINE_WIDTH / F;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] RND = AW'(1) << (2 * FACTOR_LOG2 - 1);

   dsamp_state_e              state;
   dsamp_mode_e               mode_q;
   logic [COL_W-1:0]          col;
   logic [ROW_W-1:0]          row;
   logic                      href_d;
   logic [CHANNELS*AW-1:0]    hacc;
   logic [CHANNELS*AW-1:0]    hacc_nxt;
   logic [CHANNELS*AW-1:0]    hsum;
   logic [DSAMP_LAT-1:0]      vs_pipe;

   logic                      live;
   logic                      take;
   logic                      last;
   logic                      mode_avg;
   logic                      mode_dec;
   logic [FACTOR_LOG2-1:0]    col_ph;
   logic [FACTOR_LOG2-1:0]    row_ph;
   logic                      first_row;
   logic                      emit_row;
   logic [ADDR_W-1:0]         blk_addr;

   logic                      s1_byp;
   logic                      s1_avg_emit;
   logic                      s1_dec_emit;
   logic                      s1_wr_first;
   logic                      s1_wr_add;
   logic                      s1_wr_dec;
   logic [PW-1:0]             s1_pixel;
   logic [CHANNELS*AW-1:0]    s1_hsum;
   logic [ADDR_W-1:0]         s1_addr;

   logic [CHANNELS*AW-1:0]    rd_data;
   logic [CHANNELS*AW-1:0]    wr_data;
   logic                      wr_en;
   logic [PW-1:0]             out_pix_nxt;

   // A pixel counts only inside a frame, inside the line/frame limits, and
   // never on a vsync cycle (vsync wins over href).
   assign live      = (state == DSAMP_ACTIVE) && !dsamp_in_vsync;
   assign take      = live && dsamp_in_href && (col < COL_W'(LINE_WIDTH))
                      && (row < ROW_W'(FRAME_LINES));
   assign col_ph    = col[FACTOR_LOG2-1:0];
   assign row_ph    = row[FACTOR_LOG2-1:0];
   assign last      = take && (&col_ph);
   assign first_row = (row_ph == '0);
   assign emit_row  = &row_ph;
   assign mode_avg  = (mode_q == DSAMP_AVG);
   assign mode_dec  = (mode_q == DSAMP_DECIM);
   assign blk_addr  = ADDR_W'(col >> FACTOR_LOG2);
   assign dsamp_state = state;

   // Frame control and raster counters; mode is latched only on vsync.
   always_ff @(posedge dsamp_clk or negedge dsamp_rst_n) begin
      if (!dsamp_rst_n) begin
         state  <= DSAMP_IDLE;
         mode_q <= DSAMP_BYPASS;
         col    <= '0;
         row    <= '0;
         href_d <= 1'b0;
      end else if (dsamp_in_vsync) begin
         state  <= DSAMP_ACTIVE;
         mode_q <= dsamp_mode_e'(dsamp_mode);
         col    <= '0;
         row    <= '0;
         href_d <= 1'b0;
      end else if (state == DSAMP_ACTIVE) begin
         href_d <= dsamp_in_href;
         if (dsamp_in_href) begin
            if (col < COL_W'(LINE_WIDTH)) begin
               col <= col + 1'b1;
            end
         end else begin
            col <= '0;
         end
         if (href_d && !dsamp_in_href && (row < ROW_W'(FRAME_LINES))) begin
            row <= row + 1'b1;
         end
      end
   end

   // Horizontal combine: running sum in average mode, held top-left pixel in
   // decimate mode; hsum is the completed block value on its last pixel.
   always_comb begin
      logic [AW-1:0] px_ext;
      px_ext   = '0;
      hsum     = '0;
      hacc_nxt = hacc;
      for (int c = 0; c < CHANNELS; c++) begin
         px_ext = AW'(dsamp_in_pixel[c*DATA_WIDTH +: DATA_WIDTH]);
         if (mode_avg) begin
            hsum[c*AW +: AW] = hacc[c*AW +: AW] + px_ext;
         end else begin
            hsum[c*AW +: AW] = hacc[c*AW +: AW];
         end
         if (col_ph == '0) begin
            hacc_nxt[c*AW +: AW] = px_ext;
         end else if (mode_avg) begin
            hacc_nxt[c*AW +: AW] = hacc[c*AW +: AW] + px_ext;
         end
      end
   end

   // Horizontal accumulator register, advanced on accepted pixels only.
   always_ff @(posedge dsamp_clk or negedge dsamp_rst_n) begin
      if (!dsamp_rst_n) begin
         hacc <= '0;
      end else if (take) begin
         hacc <= hacc_nxt;
      end
   end

   // Stage 1: completed block, per-mode action flags and RAM address.
   always_ff @(posedge dsamp_clk or negedge dsamp_rst_n) begin
      if (!dsamp_rst_n) begin
         s1_byp      <= 1'b0;
         s1_avg_emit <= 1'b0;
         s1_dec_emit <= 1'b0;
         s1_wr_first <= 1'b0;
         s1_wr_add   <= 1'b0;
         s1_wr_dec   <= 1'b0;
         s1_pixel    <= '0;
         s1_hsum     <= '0;
         s1_addr     <= '0;
      end else begin
         s1_byp      <= live && dsamp_in_href && !mode_avg && !mode_dec;
         s1_avg_emit <= last && mode_avg && emit_row;
         s1_dec_emit <= last && mode_dec && emit_row;
         s1_wr_first <= last && mode_avg && first_row;
         s1_wr_add   <= last && mode_avg && !first_row && !emit_row;
         s1_wr_dec   <= last && mode_dec && first_row;
         s1_pixel    <= dsamp_in_pixel;
         s1_hsum     <= hsum;
         s1_addr     <= blk_addr;
      end
   end

   dsamp_sdp_ram #(
      .DEPTH  (DEPTH),
      .WIDTH  (CHANNELS * AW),
      .ADDR_W (ADDR_W)
   ) u_acc_ram (
      .clk     (dsamp_clk),
      .wr_en   (wr_en),
      .wr_addr (s1_addr),
      .wr_data (wr_data),
      .rd_en   (last),
      .rd_addr (blk_addr),
      .rd_data (rd_data)
   );

   assign wr_en = s1_wr_first || s1_wr_add || s1_wr_dec;

   // Stage 1 datapath: vertical accumulate, write-back and output selection.
   always_comb begin
      logic [AW-1:0] rd_c;
      logic [AW-1:0] sum_c;
      rd_c        = '0;
      sum_c       = '0;
      wr_data     = '0;
      out_pix_nxt = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         rd_c  = rd_data[c*AW +: AW];
         sum_c = rd_c + s1_hsum[c*AW +: AW];
         wr_data[c*AW +: AW] = s1_wr_add ? sum_c : s1_hsum[c*AW +: AW];
         if (s1_avg_emit) begin
            out_pix_nxt[c*DATA_WIDTH +: DATA_WIDTH] =
               DATA_WIDTH'((sum_c + RND) >> (2 * FACTOR_LOG2));
         end else if (s1_dec_emit) begin
            out_pix_nxt[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rd_c);
         end
      end
      if (s1_byp) begin
         out_pix_nxt = s1_pixel;
      end
   end

   // Stage 2: registered outputs and the matching vsync delay line.
   always_ff @(posedge dsamp_clk or negedge dsamp_rst_n) begin
      if (!dsamp_rst_n) begin
         dsamp_out_href  <= 1'b0;
         dsamp_out_pixel <= '0;
         vs_pipe         <= '0;
      end else begin
         dsamp_out_href  <= s1_byp || s1_avg_emit || s1_dec_emit;
         dsamp_out_pixel <= out_pix_nxt;
         vs_pipe         <= {vs_pipe[DSAMP_LAT-2:0], dsamp_in_vsync};
      end
   end

   assign dsamp_out_vsync = vs_pipe[DSAMP_LAT-1];

endmodule

// File: tb/tb_dsamp_box.sv
// tb_dsamp_box: directed bench for dsamp_box on a reduced 256 x 8 raster
// with F = 2. Table of 2x2 mini frames plus hand-written frame sequences.
`timescale 1ns/1ps
module tb_dsamp_box;
   import dsamp_pkg::*;

   localparam int DW  = 8;
   localparam int LW  = 256;
   localparam int FLN = 8;
   localparam int NV  = 11;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   mode = 2'd0;
   logic         vsync = 1'b0;
   logic         href = 1'b0;
   logic [DW-1:0] pixel = '0;
   logic         out_vsync;
   logic         out_href;
   logic [DW-1:0] out_pixel;
   dsamp_state_e state;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   typedef struct {
      logic [1:0]    mode;
      logic [DW-1:0] p0, p1, p2, p3;
      int            n_out;
      logic [DW-1:0] exp_px;
   } vec_t;
   vec_t vecs[NV];

   dsamp_box #(
      .DATA_WIDTH  (DW),
      .CHANNELS    (1),
      .LINE_WIDTH  (LW),
      .FRAME_LINES (FLN),
      .FACTOR_LOG2 (1)
   ) dut (
      .dsamp_clk       (clk),
      .dsamp_rst_n     (rst_n),
      .dsamp_mode      (mode),
      .dsamp_in_vsync  (vsync),
      .dsamp_in_href   (href),
      .dsamp_in_pixel  (pixel),
      .dsamp_out_vsync (out_vsync),
      .dsamp_out_href  (out_href),
      .dsamp_out_pixel (out_pixel),
      .dsamp_state     (state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: every strobe pops one expected value; idle cycles carry 0.
   task automatic monitor();
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (out_href === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: got pixel %0d, expected no strobe", out_pixel);
            end else begin
               e = exp_q.pop_front();
               check("strobe_pixel", 32'(out_pixel), 32'(e));
            end
         end else begin
            check("idle_pixel_zero", 32'(out_pixel), 32'd0);
         end
      end
   endtask

   task automatic drive(input logic v, input logic h, input logic [DW-1:0] p);
      vsync = v;
      href  = h;
      pixel = p;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [1:0] m);
      mode = m;
      drive(1'b1, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
   endtask

   // kind 0: constant 100; kind 1: (line*LW + i) % 256; kind 2: i*10 + line
   function automatic logic [DW-1:0] pix_of(input int kind, input int line, input int i);
      case (kind)
         0:       return 8'd100;
         1:       return 8'((line * LW + i) % 256);
         default: return 8'(i * 10 + line);
      endcase
   endfunction

   task automatic send_line(input int kind, input int line, input int len);
      for (int i = 0; i < len; i++) begin
         drive(1'b0, 1'b1, pix_of(kind, line, i));
      end
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
   endtask

   task automatic send_frame(input int kind, input int lines, input int len);
      for (int l = 0; l < lines; l++) begin
         send_line(kind, l, len);
      end
   endtask

   // kind 0: all 100; kind 1: averaged ramp 2j+1; kind 2: decimated ramp 2j
   task automatic expect_rows(input int rows, input int per_row, input int kind);
      for (int r = 0; r < rows; r++) begin
         for (int j = 0; j < per_row; j++) begin
            if (kind == 0)      exp_q.push_back(8'd100);
            else if (kind == 1) exp_q.push_back(8'(2 * (j % 128) + 1));
            else                exp_q.push_back(8'(2 * (j % 128)));
         end
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      repeat (4) @(negedge clk);
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({"drain_", name}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{2'd2, 8'd10,  8'd11,  8'd12, 8'd13, 1, 8'd12};
      vecs[1]  = '{2'd2, 8'd255, 8'd255, 8'd255, 8'd255, 1, 8'd255};
      vecs[2]  = '{2'd2, 8'd0,   8'd0,   8'd0,  8'd1,  1, 8'd0};
      vecs[3]  = '{2'd2, 8'd0,   8'd0,   8'd1,  8'd1,  1, 8'd1};
      vecs[4]  = '{2'd2, 8'd1,   8'd2,   8'd3,  8'd4,  1, 8'd3};
      vecs[5]  = '{2'd2, 8'd7,   8'd0,   8'd0,  8'd0,  1, 8'd2};
      vecs[6]  = '{2'd2, 8'd200, 8'd100, 8'd50, 8'd25, 1, 8'd94};
      vecs[7]  = '{2'd1, 8'd9,   8'd1,   8'd2,  8'd3,  1, 8'd9};
      vecs[8]  = '{2'd1, 8'd255, 8'd0,   8'd0,  8'd0,  1, 8'd255};
      vecs[9]  = '{2'd0, 8'd5,   8'd6,   8'd7,  8'd8,  4, 8'd5};
      vecs[10] = '{2'd3, 8'd42,  8'd43,  8'd44, 8'd45, 4, 8'd42};

      fork
         monitor();
      join_none

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_vsync", 32'(out_vsync), 32'd0);
      check("reset_out_href", 32'(out_href), 32'd0);
      check("reset_out_pixel", 32'(out_pixel), 32'd0);
      check("reset_state", 32'(state), 32'(DSAMP_IDLE));
      rst_n = 1'b1;
      drive(1'b0, 1'b0, '0);

      // href before the first vsync is ignored
      mode = 2'd0;
      send_line(1, 0, 16);
      drain("pre_vsync");
      check("idle_state_held", 32'(state), 32'(DSAMP_IDLE));

      // Table of 2x2 mini frames
      for (int k = 0; k < NV; k++) begin
         start_frame(vecs[k].mode);
         if (k == 0) check("state_active", 32'(state), 32'(DSAMP_ACTIVE));
         if (vecs[k].n_out == 4) begin
            exp_q.push_back(vecs[k].p0);
            exp_q.push_back(vecs[k].p1);
            exp_q.push_back(vecs[k].p2);
            exp_q.push_back(vecs[k].p3);
         end else begin
            exp_q.push_back(vecs[k].exp_px);
         end
         drive(1'b0, 1'b1, vecs[k].p0);
         drive(1'b0, 1'b1, vecs[k].p1);
         drive(1'b0, 1'b0, '0);
         drive(1'b0, 1'b0, '0);
         drive(1'b0, 1'b1, vecs[k].p2);
         drive(1'b0, 1'b1, vecs[k].p3);
         drive(1'b0, 1'b0, '0);
         drive(1'b0, 1'b0, '0);
         drain($sformatf("vec%0d", k));
      end

      // vsync latency, bypass mode
      mode = 2'd0;
      vsync = 1'b1; href = 1'b0; pixel = '0;
      @(posedge clk); #1;
      vsync = 1'b0;
      @(negedge clk); check("vsync_lat1", 32'(out_vsync), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("vsync_lat2", 32'(out_vsync), 32'd1);
      @(posedge clk); #1;
      @(negedge clk); check("vsync_lat3", 32'(out_vsync), 32'd0);

      // bypass pixel latency of exactly two cycles
      exp_q.push_back(8'hA5);
      href = 1'b1; pixel = 8'hA5;
      @(posedge clk); #1;
      href = 1'b0; pixel = '0;
      @(negedge clk); check("byp_lat1_href", 32'(out_href), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("byp_lat2_href", 32'(out_href), 32'd1);
      check("byp_lat2_pixel", 32'(out_pixel), 32'hA5);
      @(posedge clk); #1;
      @(negedge clk); check("byp_lat3_href", 32'(out_href), 32'd0);

      // vsync coincident with href: that pixel is dropped
      drive(1'b1, 1'b1, 8'h77);
      drive(1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
      send_line(1, 0, 4);
      drain("vsync_href");

      // Average of the ramp: 1,3,...,255 on odd rows
      start_frame(2'd2);
      expect_rows(FLN / 2, LW / 2, 1);
      send_frame(1, FLN, LW);
      drain("avg_ramp");

      // Decimate of the ramp: 0,2,...,254
      start_frame(2'd1);
      expect_rows(FLN / 2, LW / 2, 2);
      send_frame(1, FLN, LW);
      drain("dec_ramp");

      // Partial right-edge block and incomplete bottom block-row dropped
      start_frame(2'd2);
      exp_q.push_back(8'd6);
      exp_q.push_back(8'd26);
      send_frame(2, 3, 5);
      drain("partial_blocks");

      // Over-long lines and a mid-frame mode switch to decimate
      start_frame(2'd2);
      expect_rows(2, LW / 2, 1);
      send_line(1, 0, LW + 2);
      send_line(1, 1, LW + 2);
      mode = 2'd1;
      send_line(1, 2, LW + 2);
      send_line(1, 3, LW + 2);
      drain("long_line_avg");
      start_frame(2'd1);
      expect_rows(1, LW / 2, 2);
      send_frame(1, 2, LW);
      drain("switched_to_dec");

      // Reset in the middle of line 3
      start_frame(2'd2);
      expect_rows(1, LW / 2, 1);
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd3);
      exp_q.push_back(8'd5);
      exp_q.push_back(8'd7);
      send_line(1, 0, LW);
      send_line(1, 1, LW);
      send_line(1, 2, LW);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, pix_of(1, 3, i));
      href = 1'b0; pixel = '0;
      @(posedge clk); #1;
      check("pre_reset_href", 32'(out_href), 32'd1);
      check("pre_reset_pixel", 32'(out_pixel), 32'd9);
      rst_n = 1'b0;
      #1;
      check("mid_reset_href", 32'(out_href), 32'd0);
      check("mid_reset_pixel", 32'(out_pixel), 32'd0);
      check("mid_reset_vsync", 32'(out_vsync), 32'd0);
      check("mid_reset_state", 32'(state), 32'(DSAMP_IDLE));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_line(1, 0, 16);
      drain("post_reset_idle");
      start_frame(2'd2);
      expect_rows(FLN / 2, LW / 2, 0);
      send_frame(0, FLN, LW);
      drain("post_reset_frame");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
